// File: rtl/serial_word_loader_pkg.sv
// Shared types and helpers for the serial word loader.
// Holds the FSM state encoding and the counter width rule used by both counters.
package serial_word_loader_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_LOAD    = 2'd2
    } state_t;

    // A counter always needs at least one bit, even when its modulus is 1.
    function automatic int cnt_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/serial_word_loader_counter.sv
// Modulo-MODULUS up counter with synchronous clear.
// Clear takes priority over enable, and tc flags the enabled wrap cycle.
module mod_counter
    import serial_word_loader_pkg::*;
#(
    parameter int MODULUS = 4,
    localparam int CW = cnt_width(MODULUS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          tc
);

    localparam logic [CW-1:0] LAST = CW'(MODULUS - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tc = (count == LAST) && en;

endmodule

// File: rtl/serial_word_loader.sv
// Collects an MSB-first serial stream into WIDTH-bit words and strobes each
// finished word into the downstream register; FRAME_WORDS words form one frame.
module serial_word_loader
    import serial_word_loader_pkg::*;
#(
    parameter int WIDTH       = 3,
    parameter int FRAME_WORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic             ser_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             ld_out,
    output logic             busy,
    output logic             done
);

    localparam int BCW = cnt_width(WIDTH);
    localparam int WCW = cnt_width(FRAME_WORDS);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(WIDTH - 1);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(FRAME_WORDS - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shift;
    logic [BCW-1:0]   bit_cnt;
    logic [WCW-1:0]   word_cnt;
    logic             bit_tc;
    logic             word_tc;
    logic             frame_start;
    logic             accept;
    logic             last_bit;

    assign frame_start = (state == S_IDLE) && start;
    assign accept      = ser_valid && ser_ready;
    assign last_bit    = accept && (bit_cnt == BIT_LAST);

    mod_counter #(.MODULUS(WIDTH)) u_bit_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (frame_start),
        .en    (accept),
        .count (bit_cnt),
        .tc    (bit_tc)
    );

    mod_counter #(.MODULUS(FRAME_WORDS)) u_word_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (frame_start),
        .en    (ld_out),
        .count (word_cnt),
        .tc    (word_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The unused encoding 2'd3 falls through to IDLE.
    always_comb begin
        state_next = S_IDLE;
        ser_ready  = 1'b0;
        busy       = 1'b0;
        ld_out     = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                state_next = start ? S_COLLECT : S_IDLE;
            end
            S_COLLECT: begin
                ser_ready  = 1'b1;
                busy       = 1'b1;
                state_next = bit_tc ? S_LOAD : S_COLLECT;
            end
            S_LOAD: begin
                ld_out     = 1'b1;
                busy       = 1'b1;
                done       = word_tc;
                state_next = (word_cnt == WORD_LAST) ? S_IDLE : S_COLLECT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // word_out captures the completed word, including the bit arriving now.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift    <= '0;
            word_out <= '0;
        end else if (frame_start) begin
            shift <= '0;
        end else if (accept) begin
            shift <= {shift[WIDTH-2:0], ser_in};
            if (last_bit) begin
                word_out <= {shift[WIDTH-2:0], ser_in};
            end
        end
    end

endmodule

// File: tb/tb_serial_word_loader.sv
// Randomized and directed bench for serial_word_loader, checked every cycle
// against a bit-queue reference model of the word/frame rules.
module tb_serial_word_loader;

    localparam int W  = 3;
    localparam int FW = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic         ser_in;
    logic         ser_valid;
    logic         ser_ready;
    logic [W-1:0] word_out;
    logic         ld_out;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model: phase 0 idle, 1 gathering bits, 2 load cycle
    int           m_phase = 0;
    bit           m_q[$];
    logic [W-1:0] m_word  = '0;
    int           m_words = 0;
    bit           m_took  = 0;

    logic [W-1:0] ld_log[$];
    int           ld_cyc[$];
    int           done_cyc[$];

    serial_word_loader #(.WIDTH(W), .FRAME_WORDS(FW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .word_out  (word_out),
        .ld_out    (ld_out),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] packBits();
        int v = 0;
        foreach (m_q[i]) v = v * 2 + int'(m_q[i]);
        return W'(v);
    endfunction

    task automatic modelStep(input bit r, input bit s, input bit v, input bit b);
        m_took = 0;
        if (r) begin
            m_phase = 0;
            m_q.delete();
            m_word  = '0;
            m_words = 0;
        end else if (m_phase == 0) begin
            if (s) begin
                m_phase = 1;
                m_q.delete();
                m_words = 0;
            end
        end else if (m_phase == 1) begin
            if (v) begin
                m_took = 1;
                m_q.push_back(b);
                if (m_q.size() == W) begin
                    m_word = packBits();
                    m_q.delete();
                    m_phase = 2;
                end
            end
        end else begin
            if (m_words == FW - 1) begin
                m_words = 0;
                m_phase = 0;
            end else begin
                m_words++;
                m_phase = 1;
            end
        end
    endtask

    task automatic checkBit(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic checkOutput();
        checkBit("ser_ready", 8'(ser_ready), 8'(m_phase == 1));
        checkBit("busy",      8'(busy),      8'(m_phase != 0));
        checkBit("ld_out",    8'(ld_out),    8'(m_phase == 2));
        checkBit("done",      8'(done),      8'(m_phase == 2 && m_words == FW - 1));
        checkBit("word_out",  8'(word_out),  8'(m_word));
    endtask

    task automatic applyStimulus(input bit r, input bit s, input bit v, input bit b);
        rst       = r;
        start     = s;
        ser_valid = v;
        ser_in    = b;
        @(posedge clk);
        modelStep(r, s, v, b);
        #1;
        cyc++;
        checkOutput();
        if (ld_out === 1'b1) begin
            ld_log.push_back(word_out);
            ld_cyc.push_back(cyc);
        end
        if (done === 1'b1) done_cyc.push_back(cyc);
    endtask

    // A bit offered during a load cycle is forced to 1 when bubble is set.
    task automatic sendBit(input bit b, input bit hs, input bit bubble);
        int guard = 0;
        do begin
            applyStimulus(0, hs, 1, (bubble && m_phase == 2) ? 1'b1 : b);
            guard++;
        end while (!m_took && guard < 20);
        total++;
        assert (m_took) else begin
            bad++;
            $error("[TB] FAIL accept_timeout cycle=%0d got=0 exp=1", cyc);
        end
    endtask

    task automatic sendWord(input logic [W-1:0] w, input bit hs, input bit bubble, input int stall);
        for (int i = 0; i < W; i++) begin
            sendBit(w[W-1-i], hs, bubble);
            if (i == 0) begin
                for (int k = 0; k < stall; k++) applyStimulus(0, hs, 0, 1'($urandom));
            end
        end
    endtask

    task automatic startFrame();
        applyStimulus(0, 1, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0);
    endtask

    initial begin
        logic [W-1:0] exp1[4];
        int first_after;
        exp1 = '{3'b101, 3'b011, 3'b111, 3'b000};
        rst = 1; start = 0; ser_valid = 0; ser_in = 0;

        // reset, then idle with valid data present
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        for (int k = 0; k < 10; k++) applyStimulus(0, 0, 1, 1'($urandom));

        // single frame, continuous stream
        ld_log.delete(); ld_cyc.delete(); done_cyc.delete();
        startFrame();
        for (int j = 0; j < 4; j++) sendWord(exp1[j], 0, 0, 0);
        idle(3);
        checkBit("f1_count", 8'(ld_log.size()), 8'd4);
        for (int j = 0; j < 4 && j < ld_log.size(); j++) checkBit("f1_word", 8'(ld_log[j]), 8'(exp1[j]));
        for (int j = 0; j + 1 < ld_cyc.size(); j++) checkBit("f1_spacing", 8'(ld_cyc[j+1] - ld_cyc[j]), 8'd4);
        checkBit("f1_done_count", 8'(done_cyc.size()), 8'd1);
        if (done_cyc.size() == 1 && ld_cyc.size() == 4) checkBit("f1_done_at", 8'(done_cyc[0]), 8'(ld_cyc[3]));

        // stall in the middle of word 2
        ld_log.delete();
        startFrame();
        sendWord(3'($urandom), 0, 0, 0);
        sendWord(3'b011, 0, 0, 5);
        sendWord(3'($urandom), 0, 0, 0);
        sendWord(3'($urandom), 0, 0, 0);
        idle(2);
        checkBit("stall_count", 8'(ld_log.size()), 8'd4);
        if (ld_log.size() > 1) checkBit("stall_word2", 8'(ld_log[1]), 8'd3);

        // ones offered during every load cycle must not leak into zero words
        ld_log.delete();
        startFrame();
        for (int j = 0; j < 4; j++) sendWord(3'b000, 0, 1, 0);
        idle(2);
        checkBit("bubble_count", 8'(ld_log.size()), 8'd4);
        foreach (ld_log[j]) checkBit("bubble_word", 8'(ld_log[j]), 8'd0);

        // reset after two bits of word 3, then a fresh frame
        startFrame();
        sendWord(3'($urandom), 0, 0, 0);
        sendWord(3'($urandom), 0, 0, 0);
        sendBit(1'b1, 0, 0);
        sendBit(1'b1, 0, 0);
        applyStimulus(1, 0, 1, 1);
        checkBit("midrst_word", 8'(word_out), 8'd0);
        ld_log.delete(); done_cyc.delete();
        for (int k = 0; k < 4; k++) applyStimulus(0, 0, 1, 1);
        checkBit("midrst_quiet", 8'(ld_log.size() + done_cyc.size()), 8'd0);
        startFrame();
        for (int j = 0; j < 4; j++) sendWord(3'($urandom), 0, 0, 0);
        idle(2);
        checkBit("midrst_refill", 8'(ld_log.size()), 8'd4);

        // back-to-back frames with start held high
        ld_cyc.delete(); done_cyc.delete();
        startFrame();
        for (int j = 0; j < 8; j++) sendWord(3'($urandom), 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        idle(3);
        checkBit("b2b_loads", 8'(ld_cyc.size()), 8'd8);
        checkBit("b2b_dones", 8'(done_cyc.size()), 8'd2);
        if (done_cyc.size() > 0) begin
            first_after = 0;
            foreach (ld_cyc[j]) if (first_after == 0 && ld_cyc[j] > done_cyc[0]) first_after = ld_cyc[j];
            checkBit("b2b_gap", 8'(first_after - done_cyc[0]), 8'd5);
        end

        // free-running random traffic
        for (int k = 0; k < 400; k++) begin
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
                          ($urandom % 4) != 0, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_word_loader.md
Name: serial_word_loader

Overview:
- Upstream feeder for the three-bit register: collects a serial bit stream into WIDTH-bit words.
- For each completed word it drives `word_out` and pulses `ld_out`. Those two outputs connect directly to the register's `in` and `ld` pins.
- One frame is FRAME_WORDS words, started by `start`; `done` pulses when the last word of the frame is loaded.
- The valid/ready serial handshake lets the bit source stall.

Parameters:
- WIDTH, 3: bits per word; matches the downstream register width.
- FRAME_WORDS, 4: words per frame; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a frame; sampled only in IDLE.
- ser_in  input  1  serial data bit, MSB of each word first.
- ser_valid  input  1  ser_in is valid this cycle.
- ser_ready  output  1  loader accepts a bit this cycle; high only in COLLECT.
- word_out  output  WIDTH  assembled word, to register `in`.
- ld_out  output  1  one-cycle load strobe, to register `ld`.
- busy  output  1  high in COLLECT and LOAD.
- done  output  1  one-cycle pulse on the final word's LOAD cycle.

Behaviour:
- One clock; reset is synchronous and active-high. All state changes on the rising edge of clk.
- Reset values:
  - state = IDLE; bit counter and word counter = 0; shift register = 0.
  - word_out = 0, ld_out = 0, busy = 0, done = 0, ser_ready = 0.
- rst asserted in any state, including mid-frame, returns everything to the reset values on the next edge. The partial word is discarded and no ld_out is issued.
- A bit is accepted only when ser_valid && ser_ready at the edge.
- On acceptance: shift register <= {shift[WIDTH-2:0], ser_in}, and the bit counter increments.
- States:
  - IDLE: ser_ready = 0, busy = 0. If start = 1, go to COLLECT and clear the bit counter, word counter and shift register. Otherwise stay.
  - COLLECT: ser_ready = 1, busy = 1.
    - On an accepted bit with bit counter = WIDTH-1: go to LOAD, wrap the bit counter to 0, and latch the complete word (including this bit) into word_out.
    - ser_valid = 0 stalls indefinitely with no state change.
  - LOAD: exactly one cycle.
    - ld_out = 1, ser_ready = 0 (any ser_valid is ignored and not consumed), busy = 1.
    - If word counter = FRAME_WORDS-1: done = 1, word counter -> 0, next state IDLE.
    - Else: word counter increments, next state COLLECT.
- Latency: word_out and ld_out are valid together in the cycle after the last bit of a word is accepted. The downstream register captures the word on the following edge.
- Back-to-back words: minimum spacing is WIDTH+1 cycles per word, because of the LOAD bubble.
- word_out holds its last value between loads; it changes only on entry to LOAD or on reset.
- start asserted in COLLECT or LOAD is ignored.
- start held high through the done cycle: IDLE is entered and the next frame begins on the following edge (IDLE lasts one cycle).
- FRAME_WORDS = 1: every LOAD also asserts done.
- Counter widths:
  - bit counter is clog2(WIDTH) bits, wraps at WIDTH-1.
  - word counter is clog2(FRAME_WORDS) bits (minimum 1), wraps at FRAME_WORDS-1.

Decomposition:
- Shared package: state encoding constants S_IDLE = 2'd0, S_COLLECT = 2'd1, S_LOAD = 2'd2 (2'd3 unused; it decodes to IDLE on the next edge).
- Sub-module mod_counter, instantiated twice (bit counter and word counter):
  - parameters: MODULUS.
  - ports: clk, rst, clr, en, count, tc.
  - tc = (count == MODULUS-1) && en.
  - clr has priority over en.
- FSM plus shift register stay in serial_word_loader.

Test Plan:
- Reset and idle: rst=1 for 2 cycles, then rst=0 with start=0 and ser_valid=1 for 10 cycles -> all outputs 0, ser_ready = 0, nothing shifted.
- Single frame, continuous stream: start for 1 cycle, then bits 1,0,1, 0,1,1, 1,1,1, 0,0,0 with ser_valid held high. Required response:
  - ld_out pulses 4 times, 4 cycles apart; word_out = 3'b101, 3'b011, 3'b111, 3'b000 in those cycles.
  - done = 1 only with the 3'b000 load; busy falls the next cycle.
  - The connected three_bit_register out follows each word one edge later.
- Stall: during word 2, drop ser_valid for 5 cycles after its first bit -> word 2 still 3'b011; no ld_out during the stall; counts unchanged.
- LOAD bubble: keep ser_valid=1 with ser_in=1 during each LOAD cycle -> that bit is not consumed; the next word is assembled only from bits presented while ser_ready=1.
- Reset mid-frame: assert rst for 1 cycle after 2 bits of word 3 -> state IDLE, word_out = 0, no ld_out, no done. A new start gives a full 4-word frame.
- Back-to-back frames: start held high throughout -> a second frame begins 1 cycle after done; the first word of frame 2 loads 5 cycles after done.
